// File: rtl/minterm_pkg.sv
// Shared types for the minterm truth-table evaluator.
// Holds the FSM state encoding and the default input count.
package minterm_pkg;

  localparam int N_IN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/minterm_mask_loader.sv
// Serial truth-table mask loader: shadow shift register, bit counter, commit.
// Ports: clk, rst, shift, clr, load_bit in; last, commit, mask_new out.
module minterm_mask_loader
  import minterm_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              clr,
  input  logic              load_bit,
  output logic              last,
  output logic              commit,
  output logic [2**N_IN-1:0] mask_new
);

  localparam int M = 2**N_IN;
  localparam logic [N_IN-1:0] ONE = 1;

  logic [M-1:0]    shadow;
  logic [N_IN-1:0] cnt;

  // MSB first: the earliest bit ends up in the top position.
  assign mask_new = {shadow[M-2:0], load_bit};
  assign last     = (cnt == '1);
  assign commit   = shift && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (clr || commit) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (shift) begin
      shadow <= mask_new;
      cnt    <= cnt + ONE;
    end
  end

endmodule

// File: rtl/minterm_lut_seq.sv
// Sequential truth-table evaluator with serial mask load and full sweep.
// Ports: CLK, RST, IN, IN_VALID, LOAD_EN, LOAD_BIT, SWEEP_START in;
//        OUT, OUT_VALID, OUT_IDX, LOAD_DONE, SWEEP_BUSY, SWEEP_DONE, ONES_CNT out.
module minterm_lut_seq
  import minterm_pkg::*;
#(
  parameter int               N_IN     = N_IN_DEF,
  parameter logic [2**N_IN-1:0] MASK_RST = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_IN-1:0] IN,
  input  logic            IN_VALID,
  input  logic            LOAD_EN,
  input  logic            LOAD_BIT,
  input  logic            SWEEP_START,
  output logic            OUT,
  output logic            OUT_VALID,
  output logic [N_IN-1:0] OUT_IDX,
  output logic            LOAD_DONE,
  output logic            SWEEP_BUSY,
  output logic            SWEEP_DONE,
  output logic [N_IN:0]   ONES_CNT
);

  localparam int M = 2**N_IN;
  localparam logic [N_IN:0] ONE = 1;

  state_t          state, nstate;
  logic [M-1:0]    mask;
  logic [M-1:0]    mask_new;
  logic [N_IN:0]   swp_cnt;
  logic [N_IN:0]   ones_acc;
  logic            shift, clr, last, commit;
  logic            ev, ev_bit, blocked;
  logic [N_IN-1:0] ev_idx;
  logic            swp_clr, swp_inc, swp_fin;

  minterm_mask_loader #(
    .N_IN(N_IN)
  ) u_loader (
    .clk      (CLK),
    .rst      (RST),
    .shift    (shift),
    .clr      (clr),
    .load_bit (LOAD_BIT),
    .last     (last),
    .commit   (commit),
    .mask_new (mask_new)
  );

  // A done pulse marks a completion cycle; new requests wait one cycle.
  assign blocked    = LOAD_DONE | SWEEP_DONE;
  assign ev_bit     = mask[ev_idx];
  assign SWEEP_BUSY = (state == SWEEP);

  always_comb begin
    nstate  = state;
    shift   = 1'b0;
    clr     = 1'b0;
    ev      = 1'b0;
    ev_idx  = IN;
    swp_clr = 1'b0;
    swp_inc = 1'b0;
    swp_fin = 1'b0;
    unique case (state)
      IDLE: begin
        if (!blocked) begin
          if (LOAD_EN) begin
            shift  = 1'b1;
            nstate = last ? IDLE : LOAD;
          end else if (SWEEP_START) begin
            swp_clr = 1'b1;
            nstate  = SWEEP;
          end else if (IN_VALID) begin
            ev = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!LOAD_EN) begin
          clr    = 1'b1;
          nstate = IDLE;
        end else begin
          shift = 1'b1;
          if (last) nstate = IDLE;
        end
      end
      SWEEP: begin
        // Extra counter bit ends the sweep without wrapping the index.
        if (swp_cnt[N_IN]) begin
          swp_fin = 1'b1;
          nstate  = IDLE;
        end else begin
          ev      = 1'b1;
          ev_idx  = swp_cnt[N_IN-1:0];
          swp_inc = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mask       <= MASK_RST;
      swp_cnt    <= '0;
      ones_acc   <= '0;
      OUT        <= 1'b0;
      OUT_VALID  <= 1'b0;
      OUT_IDX    <= '0;
      LOAD_DONE  <= 1'b0;
      SWEEP_DONE <= 1'b0;
      ONES_CNT   <= '0;
    end else begin
      state      <= nstate;
      LOAD_DONE  <= commit;
      SWEEP_DONE <= swp_fin;
      OUT_VALID  <= ev;
      if (commit) mask <= mask_new;
      if (ev) begin
        OUT     <= ev_bit;
        OUT_IDX <= ev_idx;
      end
      if (swp_clr) begin
        swp_cnt  <= '0;
        ones_acc <= '0;
      end else if (swp_inc) begin
        swp_cnt <= swp_cnt + ONE;
        if (ev_bit) ones_acc <= ones_acc + ONE;
      end
      if (swp_fin) ONES_CNT <= ones_acc;
    end
  end

endmodule

// File: doc/minterm_lut_seq.md
MINTERM_LUT_SEQ -- requirements
Module: minterm_lut_seq

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, giving the number of function inputs; mask width is 2**N_IN.
REQ-002 The block SHALL have parameter MASK_RST, default all zeros, giving the active truth-table mask value after reset.
REQ-003 The block SHALL have one clock, CLK; reset RST SHALL be synchronous and active-high.
REQ-004 Ports SHALL be, in order:
- CLK, in, 1: clock.
- RST, in, 1: synchronous active-high reset.
- IN, in, N_IN: minterm index to evaluate.
- IN_VALID, in, 1: evaluate IN this cycle.
- LOAD_EN, in, 1: serial mask load active.
- LOAD_BIT, in, 1: mask bit, MSB first.
- SWEEP_START, in, 1: start exhaustive sweep.
- OUT, out, 1: function value.
- OUT_VALID, out, 1: OUT qualifier.
- OUT_IDX, out, N_IN: minterm index that produced OUT.
- LOAD_DONE, out, 1: one-cycle pulse when a new mask is committed.
- SWEEP_BUSY, out, 1: sweep in progress.
- SWEEP_DONE, out, 1: one-cycle pulse at sweep end.
- ONES_CNT, out, N_IN+1: count of minterms that evaluated to 1 in the last sweep.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD and SWEEP, and SHALL reset to IDLE.
REQ-006 Entry priority from IDLE SHALL be LOAD_EN, then SWEEP_START, then IN_VALID.
REQ-007 In IDLE with IN_VALID=1, the block SHALL present OUT=mask[IN], OUT_IDX=IN and OUT_VALID=1 on the next cycle (latency 1); otherwise OUT_VALID SHALL be 0.
REQ-008 In LOAD, each cycle with LOAD_EN=1 SHALL shift LOAD_BIT into a shadow register; the active mask SHALL stay unchanged until commit.
REQ-009 The shadow register SHALL commit to the active mask on the cycle the 2**N_IN-th bit is taken; LOAD_DONE SHALL pulse on the following cycle, and the FSM SHALL return to IDLE.
REQ-010 LOAD_EN falling before 2**N_IN bits SHALL abort the load: the shadow register is discarded, the bit counter is cleared, there is no LOAD_DONE, and the FSM returns to IDLE.
REQ-011 SWEEP SHALL evaluate indices 0 to 2**N_IN-1, one per cycle, each with latency 1 per REQ-007.
REQ-012 SWEEP_BUSY SHALL be high from the cycle after SWEEP_START through the last OUT_VALID of the sweep.
REQ-013 The sweep counter SHALL be N_IN+1 bits; the sweep SHALL terminate on the counter's MSB, with no index wrap.
REQ-014 SWEEP_DONE SHALL pulse one cycle after the last OUT_VALID; ONES_CNT SHALL update on that same cycle and hold until the next SWEEP_DONE.
REQ-015 ONES_CNT SHALL represent 2**N_IN (all ones) without overflow.
REQ-016 IN_VALID, SWEEP_START and LOAD_EN SHALL be ignored while the FSM is in SWEEP.
REQ-017 IN_VALID and SWEEP_START SHALL be ignored while the FSM is in LOAD.
REQ-018 Requests arriving on a completion cycle SHALL be ignored; new requests SHALL be accepted only from IDLE.

Reset
REQ-019 RST SHALL set the state to IDLE, the active mask to MASK_RST, and the shadow register and all counters to 0.
REQ-020 RST SHALL drive OUT, OUT_VALID, OUT_IDX, LOAD_DONE, SWEEP_BUSY, SWEEP_DONE and ONES_CNT to 0.
REQ-021 RST asserted mid-LOAD or mid-SWEEP SHALL abandon the operation with no done pulse, and the active mask SHALL return to MASK_RST.

Structure
REQ-022 Shared package minterm_pkg SHALL hold the FSM state enum (IDLE, LOAD, SWEEP) and the default N_IN constant.
REQ-023 Serial mask loading (shadow shift register, bit counter, commit strobe) SHALL be a sub-module named minterm_mask_loader.
REQ-024 Mask storage, FSM, sweep counter and ones counter SHALL reside in the top-level module.

Verification
REQ-025 The bench SHALL check: RST held 2 cycles, N_IN=4 -> all outputs 0; IN_VALID=1, IN=0 -> OUT=0, OUT_VALID=1 next cycle.
REQ-026 The bench SHALL check: load 16'hA5C3 MSB first over 16 cycles -> single LOAD_DONE pulse; then IN=0 -> OUT=1, IN=5 -> OUT=0, IN=15 -> OUT=1.
REQ-027 The bench SHALL check: SWEEP_START after mask 16'hA5C3 -> 16 consecutive OUT_VALID with OUT_IDX 0..15 and OUT matching the mask bits; then SWEEP_DONE with ONES_CNT=8.
REQ-028 The bench SHALL check: mask 16'hFFFF, then sweep -> ONES_CNT=16 (5'b10000), no wrap.
REQ-029 The bench SHALL check: LOAD_EN dropped after 7 bits -> no LOAD_DONE, and IN=5 still returns the previous mask bit.
REQ-030 The bench SHALL check: RST at sweep index 9 -> OUT_VALID=0, SWEEP_BUSY=0, no SWEEP_DONE, and the mask equals MASK_RST.
